// File: rtl/dmx_pkg.sv
// Shared DMX512 receiver constants: 25 MHz timing defaults and the break-detector state encoding.
package dmx_pkg;

  localparam int unsigned DMX_CNT_W     = 16;
  localparam int unsigned DMX_BREAK_MIN = 2200;   // 88 us
  localparam int unsigned DMX_MAB_MIN   = 200;    // 8 us
  localparam int unsigned DMX_MAB_MAX   = 25000;  // 1 ms

  localparam int unsigned DMX_ST_W = 2;
  typedef logic [DMX_ST_W-1:0] dmx_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_MAB  = 2'd2;

endpackage

// File: rtl/dmx_sat_counter.sv
// Saturating up-counter with synchronous clear and load-one; clear has priority over load.
module dmx_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load_one,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (load_one) begin
      cnt <= W'(1);
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dmx_break_detector.sv
// DMX512 BREAK / MAB detector: times line-low and line-high intervals between edge pulses
// and flags break end, frame start (slot 0 start bit) and MAB violations.
module dmx_break_detector
  import dmx_pkg::*;
#(
  parameter int unsigned BREAK_MIN_CYC = DMX_BREAK_MIN,
  parameter int unsigned MAB_MIN_CYC   = DMX_MAB_MIN,
  parameter int unsigned MAB_MAX_CYC   = DMX_MAB_MAX,
  parameter int unsigned CNT_W         = DMX_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fall_pulse,
  input  logic             rise_pulse,
  output logic             break_det,
  output logic             frame_start,
  output logic             mab_err,
  output logic [CNT_W-1:0] break_len,
  output logic [CNT_W-1:0] mab_len
);

  localparam logic [CNT_W-1:0] BREAK_MIN_L = CNT_W'(BREAK_MIN_CYC);
  localparam logic [CNT_W-1:0] MAB_MIN_L   = CNT_W'(MAB_MIN_CYC);
  localparam logic [CNT_W-1:0] MAB_MAX_L   = CNT_W'(MAB_MAX_CYC);

  dmx_state_t       state_q;
  dmx_state_t       state_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_load;
  logic             fall_only;
  logic             rise_only;
  logic             break_det_d;
  logic             frame_start_d;
  logic             mab_err_d;
  logic [CNT_W-1:0] break_len_d;
  logic [CNT_W-1:0] mab_len_d;

  // Cycles since the edge that entered the current state; valid as length L on the terminating edge.
  dmx_sat_counter #(
    .W (CNT_W)
  ) u_len_cnt (
    .clk      (clk),
    .clr      (rst),
    .load_one (cnt_load),
    .en       (1'b1),
    .cnt      (cnt)
  );

  // Coincident edges carry no usable line level, so both are dropped.
  assign fall_only = fall_pulse & ~rise_pulse;
  assign rise_only = rise_pulse & ~fall_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      break_det   <= 1'b0;
      frame_start <= 1'b0;
      mab_err     <= 1'b0;
      break_len   <= '0;
      mab_len     <= '0;
    end else begin
      state_q     <= state_d;
      break_det   <= break_det_d;
      frame_start <= frame_start_d;
      mab_err     <= mab_err_d;
      break_len   <= break_len_d;
      mab_len     <= mab_len_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_load      = 1'b0;
    break_det_d   = 1'b0;
    frame_start_d = 1'b0;
    mab_err_d     = 1'b0;
    break_len_d   = break_len;
    mab_len_d     = mab_len;

    case (state_q)
      ST_IDLE: begin
        if (fall_only) begin
          state_d  = ST_LOW;
          cnt_load = 1'b1;
        end
      end

      ST_LOW: begin
        if (rise_only) begin
          cnt_load = 1'b1;
          if (cnt >= BREAK_MIN_L) begin
            state_d     = ST_MAB;
            break_det_d = 1'b1;
            break_len_d = cnt;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (fall_only) begin
          cnt_load = 1'b1;
        end
      end

      ST_MAB: begin
        // A fall on the timeout cycle itself still counts as a valid MAB end.
        if (fall_only) begin
          state_d  = ST_LOW;
          cnt_load = 1'b1;
          if (cnt >= MAB_MIN_L) begin
            frame_start_d = 1'b1;
            mab_len_d     = cnt;
          end else begin
            mab_err_d = 1'b1;
          end
        end else if (cnt == MAB_MAX_L) begin
          state_d   = ST_IDLE;
          mab_err_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmx_break_detector.sv
// Scoreboard bench: one default DUT and one narrow-counter DUT share random edge stimulus,
// checked against a timestamp-based model of the break/MAB rules.
module tb_dmx_break_detector;

  localparam int unsigned W0 = 16;
  localparam int unsigned W1 = 12;
  localparam int K_BRK = 0;
  localparam int K_FS  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int     kind;
    longint cyc;
    int     blen;
    int     mlen;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          fall_pulse;
  logic          rise_pulse;
  logic          brk0, fs0, err0, brk1, fs1, err1;
  logic [W0-1:0] blen0, mlen0;
  logic [W1-1:0] blen1, mlen1;

  longint cyc = 0;
  bit     done = 1'b0;
  bit     chk_zero;
  int     checks = 0;
  int     errors = 0;

  // Model: line phase 0 idle / 1 low / 2 mark-after-break, plus the cycle the phase began.
  int     p_bmin [2] = '{2200, 2200};
  int     p_mmin [2] = '{200, 200};
  int     p_mmax [2] = '{25000, 3000};
  int     p_sat  [2] = '{65535, 4095};
  int     m_ph    [2];
  longint m_start [2];
  int     m_blen  [2];
  int     m_mlen  [2];
  exp_t   q0 [$];
  exp_t   q1 [$];

  dmx_break_detector u_dut0 (
    .clk         (clk),
    .rst         (rst),
    .fall_pulse  (fall_pulse),
    .rise_pulse  (rise_pulse),
    .break_det   (brk0),
    .frame_start (fs0),
    .mab_err     (err0),
    .break_len   (blen0),
    .mab_len     (mlen0)
  );

  dmx_break_detector #(
    .BREAK_MIN_CYC (2200),
    .MAB_MIN_CYC   (200),
    .MAB_MAX_CYC   (3000),
    .CNT_W         (W1)
  ) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .fall_pulse  (fall_pulse),
    .rise_pulse  (rise_pulse),
    .break_det   (brk1),
    .frame_start (fs1),
    .mab_err     (err1),
    .break_len   (blen1),
    .mab_len     (mlen1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int i, input int k, input longint c, input int bl, input int ml);
    exp_t e;
    e.kind = k; e.cyc = c; e.blen = bl; e.mlen = ml;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int i);
    if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  task automatic step(input int i);
    logic   b, f, e, zero;
    int     bl, ml, ak, len;
    longint el;
    exp_t   x;
    if (i == 0) begin
      b = brk0; f = fs0; e = err0; bl = int'(blen0); ml = int'(mlen0);
      zero = (brk0 === 1'b0) && (fs0 === 1'b0) && (err0 === 1'b0) && (blen0 === '0) && (mlen0 === '0);
    end else begin
      b = brk1; f = fs1; e = err1; bl = int'(blen1); ml = int'(mlen1);
      zero = (brk1 === 1'b0) && (fs1 === 1'b0) && (err1 === 1'b0) && (blen1 === '0) && (mlen1 === '0);
    end

    // MAB with no falling edge for longer than the timeout
    if (m_ph[i] == 2 && cyc > m_start[i] + longint'(p_mmax[i])) begin
      push(i, K_ERR, m_start[i] + longint'(p_mmax[i]) + 1, m_blen[i], m_mlen[i]);
      m_ph[i] = 0;
    end

    if (b === 1'b1 || f === 1'b1 || e === 1'b1) begin
      ak = (b === 1'b1) ? K_BRK : (f === 1'b1) ? K_FS : K_ERR;
      checks++;
      if (int'(b === 1'b1) + int'(f === 1'b1) + int'(e === 1'b1) > 1) begin
        errors++;
        $display("FAIL onehot inst%0d cyc %0d: got brk=%b fs=%b err=%b, want at most one high", i, cyc, b, f, e);
      end
      checks++;
      if (qsize(i) == 0) begin
        errors++;
        $display("FAIL unexpected_pulse inst%0d cyc %0d: got kind %0d blen %0d mlen %0d, want no pulse", i, cyc, ak, bl, ml);
      end else begin
        x = qfront(i);
        qpop(i);
        if (x.kind != ak || x.cyc != cyc || x.blen != bl || x.mlen != ml) begin
          errors++;
          $display("FAIL pulse inst%0d: got kind %0d cyc %0d blen %0d mlen %0d, want kind %0d cyc %0d blen %0d mlen %0d",
                   i, ak, cyc, bl, ml, x.kind, x.cyc, x.blen, x.mlen);
        end
      end
    end else if (qsize(i) > 0) begin
      x = qfront(i);
      if (x.cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_pulse inst%0d cyc %0d: got no pulse, want kind %0d at cyc %0d blen %0d mlen %0d",
                 i, cyc, x.kind, x.cyc, x.blen, x.mlen);
        qpop(i);
      end
    end

    if (chk_zero) begin
      checks++;
      if (!zero) begin
        errors++;
        $display("FAIL reset_outputs inst%0d cyc %0d: got brk=%b fs=%b err=%b blen %0d mlen %0d, want all zero",
                 i, cyc, b, f, e, bl, ml);
      end
    end

    // Apply this cycle's inputs to the model.
    if (rst) begin
      m_ph[i] = 0; m_blen[i] = 0; m_mlen[i] = 0;
    end else if (fall_pulse !== rise_pulse) begin
      el  = cyc - m_start[i];
      len = (el > longint'(p_sat[i])) ? p_sat[i] : int'(el);
      case (m_ph[i])
        0: begin
          if (fall_pulse) begin m_ph[i] = 1; m_start[i] = cyc; end
        end
        1: begin
          if (rise_pulse) begin
            if (len >= p_bmin[i]) begin
              m_blen[i] = len;
              push(i, K_BRK, cyc + 1, m_blen[i], m_mlen[i]);
              m_ph[i] = 2;
            end else begin
              m_ph[i] = 0;
            end
          end
          m_start[i] = cyc;
        end
        default: begin
          if (fall_pulse) begin
            if (len >= p_mmin[i]) begin
              m_mlen[i] = len;
              push(i, K_FS, cyc + 1, m_blen[i], m_mlen[i]);
            end else begin
              push(i, K_ERR, cyc + 1, m_blen[i], m_mlen[i]);
            end
            m_ph[i] = 1;
            m_start[i] = cyc;
          end
        end
      endcase
    end
  endtask

  always @(negedge clk) begin
    step(0);
    step(1);
    if (done) begin
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      fall_pulse = 1'b0; rise_pulse = 1'b0;
    end
  endtask

  // Edge cycles are spaced exactly gap cycles apart.
  task automatic ev(input int gap, input bit f, input bit r);
    idle(gap - 1);
    @(posedge clk); #1;
    fall_pulse = f; rise_pulse = r;
  endtask

  initial begin
    int gap, cat, kd;
    rst = 1'b1; fall_pulse = 1'b0; rise_pulse = 1'b0; chk_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; chk_zero = 1'b1;
    @(posedge clk); #1; chk_zero = 1'b0;

    // Nominal 2500-cycle break, 300-cycle MAB, short start bit
    ev(10, 1, 0); ev(2500, 0, 1); ev(300, 1, 0); ev(50, 0, 1);
    // Break threshold boundary, plus a rise ignored in idle
    ev(100, 1, 0); ev(2199, 0, 1); ev(100, 0, 1);
    ev(100, 1, 0); ev(2200, 0, 1); ev(400, 1, 0); ev(40, 0, 1);
    // Short MAB, then the new low is itself a break
    ev(100, 1, 0); ev(2300, 0, 1); ev(150, 1, 0); ev(2300, 0, 1); ev(250, 1, 0); ev(40, 0, 1);
    // MAB timeout
    ev(100, 1, 0); ev(2400, 0, 1); idle(25100);
    // Break longer than the narrow counter range
    ev(10, 1, 0); ev(5000, 0, 1); ev(300, 1, 0); ev(40, 0, 1);

    // Reset mid-low abandons the measurement
    ev(100, 1, 0); idle(999);
    @(posedge clk); #1; rst = 1'b1; fall_pulse = 1'b0; rise_pulse = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    ev(5, 0, 1); idle(10);
    @(posedge clk); #1; chk_zero = 1'b1;
    @(posedge clk); #1; chk_zero = 1'b0;

    // Coincident edges mid-low change nothing
    ev(50, 1, 0); ev(1000, 1, 1); ev(1500, 0, 1); ev(300, 1, 0); ev(40, 0, 1);

    for (int n = 0; n < 20; n++) begin
      cat = int'($urandom_range(0, 19));
      if (cat < 6)       gap = int'($urandom_range(1, 20));
      else if (cat < 11) gap = int'($urandom_range(140, 260));
      else if (cat < 18) gap = int'($urandom_range(2150, 2600));
      else               gap = int'($urandom_range(2950, 3100));
      kd = int'($urandom_range(0, 9));
      if (kd == 9)         ev(gap, 1, 1);
      else if (n % 2 == 0) ev(gap, 1, 0);
      else                 ev(gap, 0, 1);
    end

    idle(5);
    done = 1'b1;
  end

endmodule

// File: doc/dmx_break_detector.md
# dmx_break_detector

Measures DMX512 line-low and line-high durations from the synchronised edge pulses produced by the per-port edge-detector stage, which sits directly upstream. It recognises BREAK and Mark-After-Break (MAB) and emits a frame-start pulse at the falling edge of slot 0's start bit. The downstream DMX UART receiver and the splitter retransmit logic use that pulse to align slot reception. It also flags MAB timing violations and reports the measured break and MAB lengths.

## Interface
- BREAK_MIN_CYC, default 2200: minimum low length that counts as a BREAK (88 µs at 25 MHz).
- MAB_MIN_CYC, default 200: minimum valid MAB (8 µs at 25 MHz).
- MAB_MAX_CYC, default 25000: MAB timeout (1 ms at 25 MHz).
- CNT_W, default 16: width of the length counter and length outputs. Requires MAB_MAX_CYC < 2^CNT_W−1 and BREAK_MIN_CYC < 2^CNT_W.
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- fall_pulse  in  1  one-cycle pulse on a synchronised line falling edge, from the upstream stage.
- rise_pulse  in  1  one-cycle pulse on a synchronised line rising edge, from the upstream stage.
- break_det  out  1  one-cycle pulse: a valid BREAK just ended.
- frame_start  out  1  one-cycle pulse: a valid MAB ended; slot 0's start bit has begun.
- mab_err  out  1  one-cycle pulse: MAB was too short or timed out.
- break_len  out  CNT_W  length of the last valid BREAK in cycles, saturating.
- mab_len  out  CNT_W  length of the last valid MAB in cycles.

## Operation
- The FSM has three states: IDLE, LOW and MAB. A single length counter `cnt` is shared by all states.
- **Counter behaviour:**
  - `cnt` loads 1 on every state entry caused by an edge.
  - Otherwise `cnt` increments every cycle and saturates at 2^CNT_W−1.
  - The registered value of `cnt` on the cycle of the terminating edge therefore equals the number of clock cycles elapsed since the starting edge (L).
- **IDLE:**
  - fall_pulse → LOW.
  - rise_pulse is ignored.
- **LOW:**
  - rise_pulse with L ≥ BREAK_MIN_CYC → break_det, break_len←L, go to MAB.
  - rise_pulse with L < BREAK_MIN_CYC → IDLE with no output. This is an ordinary data bit.
  - fall_pulse → restart LOW (cnt←1).
- **MAB:**
  - fall_pulse with MAB_MIN_CYC ≤ L → frame_start, mab_len←L, go to LOW. The start bit is then measured like any low and returns to IDLE.
  - fall_pulse with L < MAB_MIN_CYC → mab_err, go to LOW with cnt←1. The new low may itself be another BREAK.
  - cnt == MAB_MAX_CYC with no fall_pulse → mab_err, go to IDLE.
- A BREAK is detected in any state context. A BREAK arriving mid-frame restarts framing.
- **Simultaneous fall_pulse and rise_pulse:** both are ignored. The state holds and the counter keeps counting.
- break_len and mab_len hold their values until the next valid event. They are not cleared by errors.
- **Reset:** every output is 0, the state is IDLE and cnt is 0.
  - Reset asserted mid-LOW or mid-MAB abandons the measurement with no pulse.
  - If the line is held low across reset, that break is missed. The next BREAK is required.

## Timing
- All outputs are registered.
- break_det, frame_start and mab_err assert in the cycle after the triggering input edge, or after cnt reaches MAB_MAX_CYC. Each lasts exactly one cycle.
- break_len and mab_len update in the same cycle as their pulse.
- At most one of break_det, frame_start and mab_err is high in any cycle.
- A new edge is accepted on every cycle; there are no dead cycles after a pulse.
- The first cycle after rst deasserts accepts edges.

## Structure
- **Package dmx_pkg:**
  - state enum (IDLE/LOW/MAB).
  - default timing constants for 25 MHz (BREAK_MIN, MAB_MIN, MAB_MAX).
  - DMX_CNT_W.
- **Sub-module dmx_sat_counter:** a CNT_W saturating up-counter with synchronous load-1 and clear. It is natural to reuse it in the UART bit timer.
- The FSM and output registers live in dmx_break_detector.

## Test plan
- Default parameters. fall at t, rise at t+2500, fall at t+2800 → break_det at t+2501 with break_len=2500; frame_start at t+2801 with mab_len=300; mab_err never asserted.
- Low of 2199 cycles → no break_det, FSM back in IDLE. Low of exactly 2200 → break_det, break_len=2200.
- Valid BREAK, then fall after 150 cycles → mab_err one cycle later. A following rise 2300 cycles after that fall → break_det, break_len=2300.
- Valid BREAK followed by no further edge → mab_err exactly 25001 cycles after the rise cycle, FSM in IDLE, mab_len unchanged.
- Low of 70000 cycles → break_det with break_len=65535.
- rst for one cycle mid-LOW (1000 cycles in), then rise → no outputs and all outputs 0. A subsequent full 2500/300 sequence produces normal pulses. A cycle with fall_pulse and rise_pulse both high mid-LOW changes nothing.
